// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: self-test driver for an ALU + golden-result ROM pair.
// On an accepted start it latches both operands, then walks op = 0..NUM_OPS-1.
// Each op takes two cycles. In ISSUE the ROM read is issued. In WAIT the ROM
// word and the ALU result are compared. Pass/fail counts and the first failing
// op are kept in registers and hold their values after the run ends.
module alu_op_sequencer #(
    parameter int unsigned BITS      = 8,
    parameter int unsigned OP        = 4,
    parameter int unsigned SIZE      = 6,
    parameter int unsigned NUM_OPS   = 7,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [BITS-1:0] a_in,
    input  logic [BITS-1:0] b_in,
    input  logic [BITS-1:0] alu_out,
    input  logic [BITS-1:0] rom_data,
    output logic [OP-1:0]   op,
    output logic [BITS-1:0] inp1,
    output logic [BITS-1:0] inp2,
    output logic [SIZE-1:0] rom_addr,
    output logic            rom_en,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] pass_cnt,
    output logic [SIZE-1:0] fail_cnt,
    output logic            fail_seen,
    output logic [OP-1:0]   first_fail_op
);

    localparam logic [OP-1:0]   LAST_OP = OP'(NUM_OPS - 1);
    localparam logic [SIZE-1:0] BASE    = SIZE'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state;

    // Sequencer FSM. Each output is written on the edge that enters the state
    // it belongs to, so all outputs come straight from flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            op            <= '0;
            inp1          <= '0;
            inp2          <= '0;
            rom_addr      <= '0;
            rom_en        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass_cnt      <= '0;
            fail_cnt      <= '0;
            fail_seen     <= 1'b0;
            first_fail_op <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    rom_en <= 1'b0;
                    busy   <= 1'b0;
                    if (start) begin
                        inp1          <= a_in;
                        inp2          <= b_in;
                        op            <= '0;
                        rom_addr      <= BASE;
                        pass_cnt      <= '0;
                        fail_cnt      <= '0;
                        fail_seen     <= 1'b0;
                        first_fail_op <= '0;
                        rom_en        <= 1'b1;
                        busy          <= 1'b1;
                        state         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // ROM samples rom_addr on this edge; its word is valid in WAIT
                    rom_en <= 1'b0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    // An X/Z on either side leaves the condition unknown and takes the fail branch
                    if (alu_out == rom_data) begin
                        pass_cnt <= pass_cnt + SIZE'(1);
                    end else begin
                        fail_cnt <= fail_cnt + SIZE'(1);
                        if (!fail_seen) begin
                            fail_seen     <= 1'b1;
                            first_fail_op <= op;
                        end
                    end
                    if (op == LAST_OP) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        op       <= op + OP'(1);
                        rom_addr <= rom_addr + SIZE'(1);
                        rom_en   <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    // start is deliberately not looked at here
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer. It models a combinational ALU and a synchronous
// ROM preloaded with golden results, some of them deliberately corrupted.
// Expected run behaviour is derived from the op count and the ROM contents.
module tb_alu_op_sequencer;

    localparam int unsigned BITS      = 8;
    localparam int unsigned OP        = 4;
    localparam int unsigned SIZE      = 6;
    localparam int unsigned NUM_OPS   = 7;
    localparam int unsigned BASE_ADDR = 0;

    logic            clk      = 1'b0;
    logic            reset    = 1'b0;
    logic            start    = 1'b0;
    logic [BITS-1:0] a_in     = '0;
    logic [BITS-1:0] b_in     = '0;
    logic [BITS-1:0] alu_out;
    logic [BITS-1:0] rom_data = '0;
    logic [OP-1:0]   op;
    logic [BITS-1:0] inp1;
    logic [BITS-1:0] inp2;
    logic [SIZE-1:0] rom_addr;
    logic            rom_en;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] pass_cnt;
    logic [SIZE-1:0] fail_cnt;
    logic            fail_seen;
    logic [OP-1:0]   first_fail_op;

    int checks = 0;
    int errors = 0;

    logic [BITS-1:0] rom     [2**SIZE];
    logic [BITS-1:0] corrupt [NUM_OPS];

    alu_op_sequencer #(
        .BITS(BITS), .OP(OP), .SIZE(SIZE), .NUM_OPS(NUM_OPS), .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
        .alu_out(alu_out), .rom_data(rom_data), .op(op), .inp1(inp1), .inp2(inp2),
        .rom_addr(rom_addr), .rom_en(rom_en), .busy(busy), .done(done),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .fail_seen(fail_seen),
        .first_fail_op(first_fail_op)
    );

    always #5 clk = ~clk;

    // Reference ALU
    function automatic logic [BITS-1:0] alu_fn(logic [BITS-1:0] a, logic [BITS-1:0] b, logic [OP-1:0] o);
        case (o)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << 1;
            4'd6:    return ~a;
            default: return '0;
        endcase
    endfunction

    always_comb alu_out = alu_fn(inp1, inp2, op);

    // Synchronous ROM
    always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".op"}, 32'(op), 32'd0);
        check({tag, ".inp"}, 32'({inp1, inp2}), 32'd0);
        check({tag, ".rom"}, 32'({rom_addr, rom_en}), 32'd0);
        check({tag, ".busy_done"}, 32'({busy, done}), 32'd0);
        check({tag, ".cnts"}, 32'({pass_cnt, fail_cnt}), 32'd0);
        check({tag, ".fail"}, 32'({fail_seen, first_fail_op}), 32'd0);
    endtask

    task automatic clear_corrupt();
        for (int i = 0; i < int'(NUM_OPS); i++) corrupt[i] = '0;
    endtask

    task automatic load_rom(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        for (int i = 0; i < int'(NUM_OPS); i++)
            rom[BASE_ADDR + i] = alu_fn(a, b, OP'(i)) ^ corrupt[i];
    endtask

    // One run: accept on the posedge after entry, then check every cycle up
    // to the DONE cycle. abort_c >= 0 asserts reset in that cycle instead.
    task automatic run(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                       input bit hold, input bit scramble, input int abort_c, input string tag);
        int  exp_pass = 0;
        int  exp_fail = 0;
        bit  exp_seen = 1'b0;
        int  exp_first = 0;
        int  last = 2 * int'(NUM_OPS);
        int  exp_op;
        for (int i = 0; i < int'(NUM_OPS); i++) begin
            if (rom[BASE_ADDR + i] === alu_fn(a, b, OP'(i))) exp_pass++;
            else begin
                exp_fail++;
                if (!exp_seen) begin exp_seen = 1'b1; exp_first = i; end
            end
        end
        @(negedge clk);
        check({tag, ".idle_busy"}, 32'(busy), 32'd0);
        a_in = a; b_in = b; start = 1'b1;
        @(posedge clk);
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (scramble) begin a_in = BITS'($urandom); b_in = BITS'($urandom); end
            exp_op = (c / 2 < int'(NUM_OPS)) ? c / 2 : int'(NUM_OPS) - 1;
            check({tag, ".busy"}, 32'(busy), 32'(c < last));
            check({tag, ".done"}, 32'(done), 32'(c == last));
            check({tag, ".rom_en"}, 32'(rom_en), 32'(c < last && c % 2 == 0));
            check({tag, ".op"}, 32'(op), 32'(exp_op));
            check({tag, ".rom_addr"}, 32'(rom_addr), 32'(BASE_ADDR + exp_op));
            if (c == 0) begin
                check({tag, ".clr_cnt"}, 32'({pass_cnt, fail_cnt}), 32'd0);
                check({tag, ".clr_seen"}, 32'(fail_seen), 32'd0);
            end
            if (c == abort_c) begin
                reset = 1'b0;
                #1;
                check_zero({tag, ".abort"});
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check({tag, ".abort_done"}, 32'(done), 32'd0);
                end
                check_zero({tag, ".abort_hold"});
                reset = 1'b1;
                return;
            end
            if (c == last) begin
                check({tag, ".pass_cnt"}, 32'(pass_cnt), 32'(exp_pass));
                check({tag, ".fail_cnt"}, 32'(fail_cnt), 32'(exp_fail));
                check({tag, ".fail_seen"}, 32'(fail_seen), 32'(exp_seen));
                check({tag, ".first_fail_op"}, 32'(first_fail_op), 32'(exp_first));
                check({tag, ".inp"}, 32'({inp1, inp2}), 32'({a, b}));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2**SIZE; i++) rom[i] = BITS'($urandom);
        clear_corrupt();

        // 1: reset held with start high, then released with start low
        start = 1'b1;
        a_in  = 8'h5A; b_in = 8'hA5;
        for (int k = 0; k < 3; k++) begin @(negedge clk); check_zero("rst_hold"); end
        start = 1'b0;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin @(negedge clk); check_zero("rst_rel"); end

        // 2: all results match
        load_rom(8'h14, 8'h02);
        run(8'h14, 8'h02, 1'b0, 1'b0, -1, "t2");

        // 3: ROM[3] and ROM[5] have bit 0 flipped
        corrupt[3] = 8'h01; corrupt[5] = 8'h01;
        load_rom(8'h14, 8'h02);
        run(8'h14, 8'h02, 1'b0, 1'b1, -1, "t3");
        clear_corrupt();

        // 4: start held through the run and the DONE cycle
        load_rom(8'h14, 8'h02);
        run(8'h14, 8'h02, 1'b1, 1'b0, -1, "t4a");
        run(8'h14, 8'h02, 1'b1, 1'b0, -1, "t4b");
        start = 1'b0;

        // 5: reset while op=4 in WAIT, then a clean run
        run(8'h14, 8'h02, 1'b0, 1'b0, 9, "t5a");
        run(8'h14, 8'h02, 1'b0, 1'b0, -1, "t5b");

        // 6: back-to-back runs, first with a failure, second all matching
        corrupt[0] = 8'h80;
        load_rom(8'h14, 8'h02);
        run(8'h14, 8'h02, 1'b0, 1'b0, -1, "t6a");
        clear_corrupt();
        load_rom(8'hFF, 8'h01);
        run(8'hFF, 8'h01, 1'b0, 1'b0, -1, "t6b");

        // Randomized runs with random corruption
        for (int r = 0; r < 10; r++) begin
            logic [BITS-1:0] ra;
            logic [BITS-1:0] rb;
            ra = BITS'($urandom);
            rb = BITS'($urandom);
            for (int i = 0; i < int'(NUM_OPS); i++)
                corrupt[i] = ($urandom % 4 == 0) ? BITS'($urandom_range(1, 255)) : '0;
            load_rom(ra, rb);
            run(ra, rb, 1'b0, 1'b1, -1, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
